instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1, hazard hold request: freeze PC and all IF outputs.
REQ-005 The block SHALL have ports br_taken (input, 1) and br_target (input, 64), a branch redirect from a later stage.
REQ-006 The block SHALL have ports imem_req (output, 1) and imem_addr (output, 64), the instruction memory request.
REQ-007 The block SHALL have ports imem_ack (input, 1) and imem_rdata (input, 32); an ack in a cycle returns the word for the imem_addr presented in that same cycle.
REQ-008 The block SHALL have ports Inst_IF (output, 32), PC_out_IF (output, 64), Add_4_IF (output, 64) and valid_IF (output, 1), all registered, driving the IF/ID pipeline register.

Function
REQ-009 The FSM SHALL have states IDLE, FETCH and HOLD; reset enters IDLE, and IDLE moves unconditionally to FETCH after one cycle.
REQ-010 imem_req SHALL be 1 only in FETCH; imem_addr SHALL equal the internal PC in every state.
REQ-011 FETCH with ack, no stall, no br_taken SHALL load Inst_IF=imem_rdata, PC_out_IF=PC, Add_4_IF=PC+4 and valid_IF=1, and SHALL advance PC to PC+4 (one-cycle latency from ack to outputs).
REQ-012 FETCH without ack, no stall, no br_taken SHALL load a bubble: valid_IF=0, Inst_IF=0; PC, PC_out_IF and Add_4_IF hold.
REQ-013 While stall=1 and br_taken=0, all IF outputs and the PC SHALL hold their values in every state.
REQ-014 FETCH with ack and stall=1 SHALL capture imem_rdata, PC and PC+4 in a one-entry hold buffer, advance PC to PC+4 and enter HOLD.
REQ-015 HOLD SHALL keep imem_req=0; when stall=0 it SHALL move the buffered entry to the outputs with valid_IF=1 and return to FETCH.
REQ-016 br_taken=1 SHALL have highest priority in any non-reset state: PC<=br_target with bits [1:0] forced to 0, hold buffer discarded, any same-cycle ack discarded, bubble loaded (valid_IF=0, Inst_IF=0), next state FETCH; this holds even when stall=1.
REQ-017 PC+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0) with no flag.
REQ-018 br_taken in IDLE SHALL load the target PC and still transition to FETCH.

Reset
REQ-019 Asserting reset at any time SHALL immediately set state=IDLE, PC=RESET_PC, Inst_IF=0, PC_out_IF=0, Add_4_IF=0 and valid_IF=0, clear the hold buffer and, if present, both counters, and drive imem_req=0.
REQ-020 Reset mid-fetch SHALL drop any pending or same-cycle ack; the first request after release SHALL be to RESET_PC.

Configuration
REQ-021 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs fetch_count (32) and bubble_count (32): fetch_count increments when valid_IF is loaded as 1, bubble_count when valid_IF is loaded as 0 outside reset; both wrap at 2^32.
REQ-022 Without FETCH_PERF_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-023 Reset release, imem_ack tied 1 and returning words A0,A1,A2 -> imem_addr 0,4,8; valid_IF=1 with PC_out_IF 0,4,8 and Add_4_IF 4,8,12 in consecutive cycles.
REQ-024 Ack at PC=0x10 while stall=1 for 3 cycles -> outputs frozen, state HOLD, imem_req=0; after stall drops the next cycle shows PC_out_IF=0x10, then a fetch at 0x14.
REQ-025 br_taken with br_target=0x203 while stall=1 and ack=1 -> ack discarded, bubble output, next imem_addr=0x200.
REQ-026 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, ack=1 -> first instruction has Add_4_IF=0 and the next imem_addr=0.
REQ-027 Ack withheld for 2 cycles, then 1 cycle of reset asserted mid-wait -> outputs zero, and the first request after release is to RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage_if
// Instruction memory request/response bundle for the fetch stage.
//   imem_req   : fetch stage is requesting a word this cycle
//   imem_addr  : byte address of the requested word (always the fetch PC)
//   imem_ack   : memory returns imem_rdata for the address of this cycle
//   imem_rdata : 32-bit instruction word
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instruction_fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
// IF stage of a 64-bit pipeline: owns the PC, requests instruction words
// from instruction memory and loads the IF/ID pipeline register.
//
// Parameters:
//   RESET_PC     : PC value loaded on reset
// Ports:
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous active-high reset
//   stall        : hazard hold, freezes PC and IF outputs
//   br_taken     : redirect from a later stage (highest priority)
//   br_target    : redirect address, low two bits are forced to zero
//   imem         : instruction memory bundle (master side)
//   Inst_IF      : fetched instruction word (0 for a bubble)
//   PC_out_IF    : PC of the fetched instruction
//   Add_4_IF     : PC_out_IF + 4 (wraps modulo 2^64)
//   valid_IF     : IF/ID register holds a real instruction
// Optional (macro FETCH_PERF_CNT_EN):
//   fetch_count  : number of valid instructions loaded, wraps at 2^32
//   bubble_count : number of bubbles loaded, wraps at 2^32
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       br_taken,
  input  logic [63:0]                br_target,
  instruction_fetch_stage_if.master  imem,
  output logic [31:0]                Inst_IF,
  output logic [63:0]                PC_out_IF,
  output logic [63:0]                Add_4_IF,
  output logic                       valid_IF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_count,
  output logic [31:0]                bubble_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic [31:0] hold_inst;
  logic [63:0] hold_pc;
  logic [63:0] hold_add4;
  logic        load_fetch;
  logic        load_bubble;

  assign pc_plus4       = pc + 64'd4;
  assign imem.imem_addr = pc;
  assign imem.imem_req  = (state == FETCH);

  // Classify what the IF/ID register receives this cycle. A redirect always
  // produces a bubble, even under stall, so it is checked first.
  always_comb begin
    load_fetch  = 1'b0;
    load_bubble = 1'b0;
    if (br_taken) begin
      load_bubble = (state == IDLE) || (state == FETCH) || (state == HOLD);
    end else if (!stall) begin
      load_fetch  = ((state == FETCH) && imem.imem_ack) || (state == HOLD);
      load_bubble = (state == FETCH) && !imem.imem_ack;
    end
  end

  // Main FSM with PC, hold buffer and IF/ID register. A word acked while
  // stalled cannot be refetched cheaply, so it is parked in the hold buffer
  // and the PC moves on; HOLD releases it once the stall clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      Inst_IF   <= 32'd0;
      PC_out_IF <= 64'd0;
      Add_4_IF  <= 64'd0;
      valid_IF  <= 1'b0;
      hold_inst <= 32'd0;
      hold_pc   <= 64'd0;
      hold_add4 <= 64'd0;
    end else if (br_taken) begin
      state     <= FETCH;
      pc        <= br_target & ~64'd3;
      Inst_IF   <= 32'd0;
      valid_IF  <= 1'b0;
      hold_inst <= 32'd0;
      hold_pc   <= 64'd0;
      hold_add4 <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (load_fetch) begin
            Inst_IF   <= imem.imem_rdata;
            PC_out_IF <= pc;
            Add_4_IF  <= pc_plus4;
            valid_IF  <= 1'b1;
            pc        <= pc_plus4;
          end else if (load_bubble) begin
            Inst_IF  <= 32'd0;
            valid_IF <= 1'b0;
          end else if (imem.imem_ack) begin
            hold_inst <= imem.imem_rdata;
            hold_pc   <= pc;
            hold_add4 <= pc_plus4;
            pc        <= pc_plus4;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (load_fetch) begin
            Inst_IF   <= hold_inst;
            PC_out_IF <= hold_pc;
            Add_4_IF  <= hold_add4;
            valid_IF  <= 1'b1;
            state     <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters follow the IF/ID valid bit as it is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (load_fetch) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (load_bubble) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage
// Self-checking bench for instruction_fetch_stage: directed scenarios for
// sequential fetch, stall/hold, redirect under stall, PC wrap and reset
// mid-wait, followed by randomized stall/branch/ack traffic. Expected values
// come from a transaction-level model (PC, pending-word queue, outputs).
// Counter checks are included when FETCH_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic [31:0] Inst_IF;
  logic [63:0] PC_out_IF;
  logic [63:0] Add_4_IF;
  logic        valid_IF;
  logic [31:0] Inst_IF_w;
  logic [63:0] PC_out_IF_w;
  logic [63:0] Add_4_IF_w;
  logic        valid_IF_w;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
  logic [31:0] fetch_count_w;
  logic [31:0] bubble_count_w;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage_if bus ();
  instruction_fetch_stage_if bus_w ();

  instruction_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem      (bus),
    .Inst_IF   (Inst_IF),
    .PC_out_IF (PC_out_IF),
    .Add_4_IF  (Add_4_IF),
    .valid_IF  (valid_IF)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
`endif
  );

  // Second instance starting just below the top of the address space.
  instruction_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk       (clk),
    .reset     (reset),
    .stall     (1'b0),
    .br_taken  (1'b0),
    .br_target (64'd0),
    .imem      (bus_w),
    .Inst_IF   (Inst_IF_w),
    .PC_out_IF (PC_out_IF_w),
    .Add_4_IF  (Add_4_IF_w),
    .valid_IF  (valid_IF_w)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count_w),
    .bubble_count (bubble_count_w)
`endif
  );

  // Reference model state
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } entry_t;

  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [63:0] m_pcout;
  logic [63:0] m_add4;
  logic        m_valid;
  logic        m_idle;
  entry_t      m_buf[$];
  logic [31:0] m_fetches;
  logic [31:0] m_bubbles;

  function automatic logic [31:0] memword(input logic [63:0] addr);
    return 32'hA000_0000 + 32'(addr[31:2]) + {addr[47:40], 24'h0};
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc      = 64'h0;
    m_inst    = 32'd0;
    m_pcout   = 64'd0;
    m_add4    = 64'd0;
    m_valid   = 1'b0;
    m_idle    = 1'b1;
    m_buf.delete();
    m_fetches = 32'd0;
    m_bubbles = 32'd0;
  endtask

  // One clock of the fetch stage at transaction level: a redirect wins,
  // the first cycle after reset does nothing, a parked word drains when the
  // stall clears, otherwise an ack delivers (or parks) a word.
  task automatic modelStep(input logic s, input logic b, input logic [63:0] t,
                           input logic a, input logic [31:0] d);
    entry_t e;
    if (b) begin
      m_pc    = t & ~64'd3;
      m_buf.delete();
      m_inst  = 32'd0;
      m_valid = 1'b0;
      m_idle  = 1'b0;
      m_bubbles++;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_buf.size() > 0) begin
      if (!s) begin
        e       = m_buf.pop_front();
        m_inst  = e.inst;
        m_pcout = e.pc;
        m_add4  = e.pc + 64'd4;
        m_valid = 1'b1;
        m_fetches++;
      end
    end else if (s) begin
      if (a) begin
        e.inst = d;
        e.pc   = m_pc;
        m_buf.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end else if (a) begin
      m_inst  = d;
      m_pcout = m_pc;
      m_add4  = m_pc + 64'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 64'd4;
      m_fetches++;
    end else begin
      m_inst  = 32'd0;
      m_valid = 1'b0;
      m_bubbles++;
    end
  endtask

  task automatic checkOutput();
    checkVal("imem_req",  bus.imem_req, !m_idle && (m_buf.size() == 0));
    checkVal("imem_addr", bus.imem_addr, m_pc);
    checkVal("Inst_IF",   Inst_IF, m_inst);
    checkVal("PC_out_IF", PC_out_IF, m_pcout);
    checkVal("Add_4_IF",  Add_4_IF, m_add4);
    checkVal("valid_IF",  valid_IF, m_valid);
`ifdef FETCH_PERF_CNT_EN
    checkVal("fetch_count",  fetch_count, m_fetches);
    checkVal("bubble_count", bubble_count, m_bubbles);
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input logic s, input logic b, input logic [63:0] t, input logic a);
    logic [31:0] d;
    d = a ? memword(m_pc) : 32'hDEAD_BEEF;
    stall          = s;
    br_taken       = b;
    br_target      = t;
    bus.imem_ack   = a;
    bus.imem_rdata = d;
    @(posedge clk);
    #1;
    modelStep(s, b, t, a, d);
    checkOutput();
  endtask

  // Asynchronous reset: effects are checked before any clock edge.
  task automatic doReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput();
  endtask

  initial begin
    reset            = 1'b0;
    stall            = 1'b0;
    br_taken         = 1'b0;
    br_target        = 64'd0;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'd0;
    bus_w.imem_ack   = 1'b1;
    bus_w.imem_rdata = 32'hC0DE_0001;
    modelReset();
    #2;
    doReset();

    // Sequential fetch with ack always high
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkVal("first_req", bus.imem_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
      checkVal("seq_pc_out", PC_out_IF, 64'(4 * i));
      checkVal("seq_add4", Add_4_IF, 64'(4 * i + 4));
      checkVal("seq_inst", Inst_IF, 32'hA000_0000 + 32'(i));
      checkVal("seq_valid", valid_IF, 1'b1);
      if (i == 0) begin
        checkVal("wrap_pc_out", PC_out_IF_w, 64'hFFFF_FFFF_FFFF_FFFC);
        checkVal("wrap_add4", Add_4_IF_w, 64'd0);
        checkVal("wrap_next_addr", bus_w.imem_addr, 64'd0);
        checkVal("wrap_valid", valid_IF_w, 1'b1);
      end
    end

    // Ack at PC 0x10 while stalled for 3 cycles
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkVal("pre_stall_addr", bus.imem_addr, 64'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 64'd0, 1'b1);
      checkVal("hold_req", bus.imem_req, 1'b0);
      checkVal("hold_pc_out", PC_out_IF, 64'hC);
    end
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    checkVal("release_pc_out", PC_out_IF, 64'h10);
    checkVal("release_addr", bus.imem_addr, 64'h14);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkVal("after_hold_pc_out", PC_out_IF, 64'h14);

    // Redirect under stall with a same-cycle ack
    applyStimulus(1'b1, 1'b1, 64'h203, 1'b1);
    checkVal("br_valid", valid_IF, 1'b0);
    checkVal("br_inst", Inst_IF, 32'd0);
    checkVal("br_addr", bus.imem_addr, 64'h200);

    // Ack withheld, then reset mid-wait
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    bus.imem_ack = 1'b1;
    doReset();
    checkVal("rst_valid", valid_IF, 1'b0);
    checkVal("rst_pc_out", PC_out_IF, 64'd0);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    checkVal("rst_first_addr", bus.imem_addr, 64'd0);
    checkVal("rst_first_req", bus.imem_req, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 8,
                      ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                  : {$urandom, $urandom},
                      $urandom_range(0, 99) < 60);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
